// File: rtl/iq_polar_cordic.sv
// Pipelined vectoring CORDIC: signed I/Q in, gain-compensated magnitude and
// 16-bit phase out, one sample per clock, STAGES+2 register stages.
module iq_polar_cordic #(
    parameter int W      = 14,
    parameter int STAGES = 14
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] I,
    input  logic [W-1:0] Q,
    output logic         out_valid,
    output logic [W-1:0] mag,
    output logic [15:0]  phase
);

    // Guard bits below the integer LSB keep the floor bias of the late
    // micro-rotations (small negative y >>> i) out of the magnitude.
    localparam int GUARD = 4;
    localparam int XW    = W + 3 + GUARD;
    localparam int PW    = XW + 17;
    localparam int unsigned NS = STAGES;

    localparam logic signed [PW-1:0] GAIN    = PW'(39797);
    localparam logic signed [PW-1:0] MAG_MAX = PW'((2 ** W) - 1);

    typedef logic signed [XW-1:0] xy_t;

    xy_t         xs [0:STAGES];
    xy_t         ys [0:STAGES];
    logic [15:0] zs [0:STAGES];
    logic        vs [0:STAGES];
    logic        zf [0:STAGES];

    xy_t         i_ext, q_ext, x_p, y_p;
    logic [15:0] z_p;

    logic signed [PW-1:0] scaled;
    logic [W-1:0]         mag_c;

    function automatic logic [15:0] atan_lut(input int unsigned i);
        case (i)
            0:       atan_lut = 16'd8192;
            1:       atan_lut = 16'd4836;
            2:       atan_lut = 16'd2555;
            3:       atan_lut = 16'd1297;
            4:       atan_lut = 16'd651;
            5:       atan_lut = 16'd326;
            6:       atan_lut = 16'd163;
            7:       atan_lut = 16'd81;
            8:       atan_lut = 16'd41;
            9:       atan_lut = 16'd20;
            10:      atan_lut = 16'd10;
            11:      atan_lut = 16'd5;
            12:      atan_lut = 16'd3;
            13:      atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    // Fold the left half-plane onto the right so x >= 0 entering the rotations.
    always_comb begin
        i_ext = {{3{I[W-1]}}, I, {GUARD{1'b0}}};
        q_ext = {{3{Q[W-1]}}, Q, {GUARD{1'b0}}};
        x_p   = i_ext;
        y_p   = q_ext;
        z_p   = '0;
        if (I[W-1]) begin
            if (!Q[W-1]) begin
                x_p = q_ext;
                y_p = -i_ext;
                z_p = 16'h4000;
            end else begin
                x_p = -q_ext;
                y_p = i_ext;
                z_p = 16'hC000;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i <= NS; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                zs[i] <= '0;
                vs[i] <= 1'b0;
                zf[i] <= 1'b0;
            end
        end else begin
            xs[0] <= x_p;
            ys[0] <= y_p;
            zs[0] <= z_p;
            vs[0] <= in_valid;
            zf[0] <= (I == '0) && (Q == '0);
            for (int unsigned i = 0; i < NS; i++) begin
                if (!ys[i][XW-1]) begin
                    xs[i+1] <= xs[i] + (ys[i] >>> i);
                    ys[i+1] <= ys[i] - (xs[i] >>> i);
                    zs[i+1] <= zs[i] + atan_lut(i);
                end else begin
                    xs[i+1] <= xs[i] - (ys[i] >>> i);
                    ys[i+1] <= ys[i] + (xs[i] >>> i);
                    zs[i+1] <= zs[i] - atan_lut(i);
                end
                vs[i+1] <= vs[i];
                zf[i+1] <= zf[i];
            end
        end
    end

    always_comb begin
        scaled = (PW'(xs[STAGES]) * GAIN) >>> (16 + GUARD);
        mag_c  = '0;
        if (scaled > MAG_MAX)
            mag_c = '1;
        else if (!scaled[PW-1])
            mag_c = scaled[W-1:0];
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            mag       <= '0;
            phase     <= '0;
        end else begin
            out_valid <= vs[STAGES];
            mag       <= zf[STAGES] ? '0 : mag_c;
            phase     <= zf[STAGES] ? '0 : zs[STAGES];
        end
    end

endmodule
